// File: rtl/sensor_pkg.sv
// Shared types and default parameters for the PISO sensor-chain scanner.
package sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE,
        GAP
    } scan_state_t;

    localparam int DEF_BITS           = 32;
    localparam int DEF_N_CHAINS       = 1;
    localparam int DEF_DIV_HALF       = 64;
    localparam int DEF_SCAN_GAP       = 6000;
    localparam int DEF_DEBOUNCE_SCANS = 2;

endpackage

// File: rtl/sensor_debounce.sv
// Debounces complete scan words: commits after DEBOUNCE_SCANS consecutive identical scans.
module sensor_debounce
    import sensor_pkg::*;
#(
    parameter int W              = DEF_BITS * DEF_N_CHAINS,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] scan_word,
    input  logic         scan_done,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    output logic         data_changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [W-1:0]     prev_scan;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] match_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

    // A zero count means no history, so a stale prev_scan can never extend a run.
    always_comb begin
        match_nxt = CNT_W'(1);
        if (match_cnt != '0 && scan_word == prev_scan)
            match_nxt = sat_inc(match_cnt);
    end

    always_ff @(posedge clk) begin
        if (scan_done)
            prev_scan <= scan_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_cnt    <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            data_changed <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            data_changed <= 1'b0;
            if (scan_done) begin
                match_cnt <= match_nxt;
                if (match_nxt == CNT_MAX) begin
                    data_out     <= scan_word;
                    data_valid   <= 1'b1;
                    data_changed <= (scan_word != data_out);
                end
            end
        end
    end

endmodule

// File: rtl/sensor_scan_controller.sv
// Drives shared sr_clk/sr_load_n to N_CHAINS 74HC165 chains, shifts in BITS per chain, debounces the result.
module sensor_scan_controller
    import sensor_pkg::*;
#(
    parameter int BITS           = DEF_BITS,
    parameter int N_CHAINS       = DEF_N_CHAINS,
    parameter int DIV_HALF       = DEF_DIV_HALF,
    parameter int SCAN_GAP       = DEF_SCAN_GAP,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     auto_mode,
    input  logic                     start,
    output logic                     sr_clk,
    output logic                     sr_load_n,
    input  logic [N_CHAINS-1:0]      sr_data,
    output logic [N_CHAINS*BITS-1:0] data_out,
    output logic                     data_valid,
    output logic                     data_changed,
    output logic                     busy
);

    localparam int DIV_W = $clog2(DIV_HALF + 1);
    localparam int BIT_W = $clog2(BITS + 1);
    localparam int GAP_W = $clog2(SCAN_GAP + 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);

    scan_state_t               state;
    logic [DIV_W-1:0]          div_cnt;
    logic [BIT_W-1:0]          bit_idx;
    logic [GAP_W-1:0]          gap_cnt;
    logic                      scan_done;
    logic [BITS-1:0]           scan_bits [N_CHAINS];
    logic [N_CHAINS*BITS-1:0]  scan_word;

    wire sample_now = (state == SHIFT_LO) && (div_cnt == DIV_LAST);

    // Shift right from the top so the first bit after load lands at index 0.
    for (genvar g = 0; g < N_CHAINS; g++) begin : g_chain
        always_ff @(posedge clk) begin
            if (sample_now)
                scan_bits[g] <= (scan_bits[g] >> 1) | (BITS'(sr_data[g]) << (BITS - 1));
        end
        assign scan_word[g*BITS +: BITS] = scan_bits[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sr_clk    <= 1'b0;
            sr_load_n <= 1'b1;
            busy      <= 1'b0;
            div_cnt   <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || (auto_mode && gap_cnt == GAP_LAST)) begin
                        state     <= LOAD;
                        sr_load_n <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                        bit_idx   <= '0;
                        gap_cnt   <= '0;
                    end else if (auto_mode) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else begin
                        gap_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (div_cnt == DIV_LAST) begin
                        state     <= SHIFT_LO;
                        sr_load_n <= 1'b1;
                        div_cnt   <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= SHIFT_HI;
                        sr_clk  <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        sr_clk  <= 1'b0;
                        div_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state     <= DONE;
                            scan_done <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    gap_cnt <= '0;
                    state   <= auto_mode ? GAP : IDLE;
                end
                GAP: begin
                    if (!auto_mode) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state     <= LOAD;
                        sr_load_n <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                        bit_idx   <= '0;
                        gap_cnt   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sensor_debounce #(
        .W              (N_CHAINS * BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .scan_word    (scan_word),
        .scan_done    (scan_done),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_changed (data_changed)
    );

endmodule
